// File: rtl/binary_div_15_8_bi.sv
// Bit-serial signed restoring divider (NW-bit dividend / DW-bit divisor).
// Produces one quotient bit per enabled cycle. The quotient truncates toward zero,
// and the remainder takes the sign of the dividend. Divide-by-zero and the single
// overflowing pair (most negative dividend / -1) are flagged alongside the result.
module binary_div_15_8_bi #(
  parameter int NW = 15,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [NW-1:0] N,
  input  logic [DW-1:0] D,
  output logic [NW-1:0] Q,
  output logic [DW-1:0] R,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic          ovf
);

  localparam int CW = $clog2(NW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT         stateQ, stateD;

  // Operand working registers. workNQ shifts the dividend out at its MSB and
  // collects quotient bits at its LSB, so after NW iterations it holds |quotient|.
  logic [NW-1:0] workNQ, workND;
  logic [DW-1:0] workDQ, workDD;
  logic [DW:0]   remQ, remD;
  logic [CW-1:0] cntQ, cntD;
  logic          primedQ, primedD;
  logic          quoSignQ, quoSignD;
  logic          remSignQ, remSignD;
  logic          divZeroQ, divZeroD;
  logic          ovfPendQ, ovfPendD;

  // Registered results and status
  logic [NW-1:0] quotientQ, quotientD;
  logic [DW-1:0] remainderQ, remainderD;
  logic          busyQ, busyD;
  logic          doneQ, doneD;
  logic          dzQ, dzD;
  logic          ovfQ, ovfD;

  // Trial-subtraction datapath for one restoring step
  logic [DW+1:0] shifted;
  logic [DW+1:0] trialDiff;
  logic          trialOk;

  // One restoring step: shift in the next dividend bit, then subtract |D|;
  // a clear borrow bit means the subtraction is kept and the quotient bit is 1.
  always_comb begin
    shifted   = {remQ, workNQ[NW-1]};
    trialDiff = shifted - {2'b00, workDQ};
    trialOk   = ~trialDiff[DW+1];
  end

  // State and datapath registers; nothing moves unless en is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      workNQ     <= '0;
      workDQ     <= '0;
      remQ       <= '0;
      cntQ       <= '0;
      primedQ    <= 1'b0;
      quoSignQ   <= 1'b0;
      remSignQ   <= 1'b0;
      divZeroQ   <= 1'b0;
      ovfPendQ   <= 1'b0;
      quotientQ  <= '0;
      remainderQ <= '0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
      dzQ        <= 1'b0;
      ovfQ       <= 1'b0;
    end else if (en) begin
      stateQ     <= stateD;
      workNQ     <= workND;
      workDQ     <= workDD;
      remQ       <= remD;
      cntQ       <= cntD;
      primedQ    <= primedD;
      quoSignQ   <= quoSignD;
      remSignQ   <= remSignD;
      divZeroQ   <= divZeroD;
      ovfPendQ   <= ovfPendD;
      quotientQ  <= quotientD;
      remainderQ <= remainderD;
      busyQ      <= busyD;
      doneQ      <= doneD;
      dzQ        <= dzD;
      ovfQ       <= ovfD;
    end
  end

  // Next-state logic: accept, convert to magnitudes, iterate, then sign-fix.
  always_comb begin
    stateD     = stateQ;
    workND     = workNQ;
    workDD     = workDQ;
    remD       = remQ;
    cntD       = cntQ;
    primedD    = primedQ;
    quoSignD   = quoSignQ;
    remSignD   = remSignQ;
    divZeroD   = divZeroQ;
    ovfPendD   = ovfPendQ;
    quotientD  = quotientQ;
    remainderD = remainderQ;
    busyD      = busyQ;
    doneD      = 1'b0;
    dzD        = dzQ;
    ovfD       = ovfQ;

    case (stateQ)
      IDLE: begin
        if (start) begin
          // Raw operands are captured here and converted to magnitudes on the
          // first CALC cycle, keeping negation off the accept path.
          stateD   = CALC;
          busyD    = 1'b1;
          quoSignD = N[NW-1] ^ D[DW-1];
          remSignD = N[NW-1];
          workND   = N;
          workDD   = D;
          remD     = '0;
          cntD     = CW'(NW - 1);
          primedD  = 1'b0;
          divZeroD = (D == '0);
          ovfPendD = (N == {1'b1, {(NW-1){1'b0}}}) && (D == '1);
        end
      end

      CALC: begin
        if (!primedQ) begin
          // |most negative| still fits as an unsigned value of the same width.
          primedD = 1'b1;
          workND  = remSignQ ? (~workNQ + NW'(1)) : workNQ;
          workDD  = (quoSignQ ^ remSignQ) ? (~workDQ + DW'(1)) : workDQ;
        end else begin
          remD   = trialOk ? trialDiff[DW:0] : shifted[DW:0];
          workND = {workNQ[NW-2:0], trialOk};
          cntD   = cntQ - 1'b1;
          if (cntQ == '0) begin
            stateD = FIX;
          end
        end
      end

      FIX: begin
        // A zero divisor forces a clean zero result instead of the all-ones
        // quotient the iteration would otherwise leave behind.
        stateD = IDLE;
        busyD  = 1'b0;
        doneD  = 1'b1;
        dzD    = divZeroQ;
        ovfD   = ovfPendQ;
        if (divZeroQ) begin
          quotientD  = '0;
          remainderD = '0;
        end else begin
          quotientD  = quoSignQ ? (~workNQ + NW'(1)) : workNQ;
          remainderD = remSignQ ? (~remQ[DW-1:0] + DW'(1)) : remQ[DW-1:0];
        end
      end

      default: begin
        stateD = IDLE;
      end
    endcase
  end

  assign Q    = quotientQ;
  assign R    = remainderQ;
  assign busy = busyQ;
  assign done = doneQ;
  assign dz   = dzQ;
  assign ovf  = ovfQ;

endmodule
